// File: rtl/real_accum_stage.sv
// rtl/real_accum_stage.sv - windowed fixed-point accumulator between two svreal formats
// Optional saturating narrow() with sat_flag output: define SVREAL_ACCUM_SAT_EN.
module real_accum_stage #(
  parameter int in_width     = 16,
  parameter int in_exponent  = -8,
  parameter int out_width    = 18,
  parameter int out_exponent = -10,
  parameter int N            = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [in_width-1:0]      in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [out_width-1:0]     out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N+1)-1:0]   count
`ifdef SVREAL_ACCUM_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int CW  = $clog2(N + 1);
  localparam int AW  = out_width + $clog2(N) + 1;
  localparam int SHL = (in_exponent >= out_exponent) ? (in_exponent - out_exponent) : 0;
  localparam int SHR = (in_exponent >= out_exponent) ? 0 : (out_exponent - in_exponent);
  localparam int EW  = (in_width > AW) ? in_width : AW;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]               state;
  logic signed [AW-1:0]     acc;
  logic signed [EW-1:0]     in_ext;
  logic signed [AW-1:0]     aligned;
  logic signed [AW-1:0]     sum;
  logic [out_width-1:0]     narrowed;
  logic                     accept;
  logic                     last;

  assign in_ready = (state == ST_ACC) && !clear;
  assign accept   = in_valid && in_ready;
  assign last     = (count == CW'(N - 1));

  // Arithmetic shifts keep the sign, so a right shift floors toward -inf.
  assign in_ext  = EW'(signed'(in));
  assign aligned = AW'((in_ext <<< SHL) >>> SHR);
  assign sum     = acc + aligned;

`ifdef SVREAL_ACCUM_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

  logic sat_hi;
  logic sat_lo;

  assign sat_hi = (sum > SAT_MAX);
  assign sat_lo = (sum < SAT_MIN);

  always_comb begin
    narrowed = sum[out_width-1:0];
    if (sat_hi) begin
      narrowed = SAT_MAX[out_width-1:0];
    end else if (sat_lo) begin
      narrowed = SAT_MIN[out_width-1:0];
    end
  end
`else
  assign narrowed = sum[out_width-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef SVREAL_ACCUM_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ACC: begin
          if (clear) begin
            acc   <= '0;
            count <= '0;
          end else if (accept) begin
            if (last) begin
              out       <= narrowed;
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= ST_HOLD;
`ifdef SVREAL_ACCUM_SAT_EN
              sat_flag  <= sat_hi || sat_lo;
`endif
            end else begin
              acc   <= sum;
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          // The completed sum stays put until taken; clear and inputs are ignored here.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
`ifdef SVREAL_ACCUM_SAT_EN
            sat_flag  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_real_accum_stage.sv
// tb/tb_real_accum_stage.sv - self-checking bench for real_accum_stage (default formats, N=4)
// Honours SVREAL_ACCUM_SAT_EN to match the saturating build.
module tb_real_accum_stage;

  localparam int IW    = 16;
  localparam int OW    = 18;
  localparam int NS    = 4;
  localparam int CW    = $clog2(NS + 1);
  localparam longint SCALE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IW-1:0]   in_d = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            clear = 1'b0;
  logic [OW-1:0]   out_d;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   count;
`ifdef SVREAL_ACCUM_SAT_EN
  logic            sat_flag;
`endif

  int checks = 0;
  int failures = 0;

  real_accum_stage #(
    .in_width(IW), .in_exponent(-8), .out_width(OW), .out_exponent(-10), .N(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_d), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .out(out_d), .out_valid(out_valid), .out_ready(out_ready), .count(count)
`ifdef SVREAL_ACCUM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    int     smp [NS];
    longint exp_out;
    bit     exp_sat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint out_s();
    return longint'($signed(out_d));
  endfunction

  // Reference narrow(): plain integer clamp or two's-complement wrap to OW bits.
  function automatic longint narrow_ref(input longint s);
    longint hi, lo, r;
    hi = (64'sd1 <<< (OW - 1)) - 1;
    lo = -(64'sd1 <<< (OW - 1));
`ifdef SVREAL_ACCUM_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    r = s & ((64'sd1 <<< OW) - 1);
    if (r > hi) r = r - (64'sd1 <<< OW);
    return r;
`endif
  endfunction

  function automatic bit clip_ref(input longint s);
    return (s > (64'sd1 <<< (OW - 1)) - 1) || (s < -(64'sd1 <<< (OW - 1)));
  endfunction

  task automatic accept(input int v);
    int budget;
    budget = 0;
    in_d = IW'(v);
    in_valid = 1'b1;
    #1;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_sat(input string name, input bit exp);
`ifdef SVREAL_ACCUM_SAT_EN
    chk(name, longint'(sat_flag), longint'(exp));
`else
    if (exp) chk(name, 0, 0);
`endif
  endtask

  vec_t vecs [4];
  longint model_sum;
  longint exp_o;
  int     v;
  int     gap;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].name = "basic_1p5";  vecs[0].smp = '{384, 384, 384, 384};
    vecs[0].exp_out = 6144;      vecs[0].exp_sat = 1'b0;
    vecs[1].name = "mixed_sign"; vecs[1].smp = '{576, -256, 128, -960};
    vecs[1].exp_out = -2048;     vecs[1].exp_sat = 1'b0;
`ifdef SVREAL_ACCUM_SAT_EN
    vecs[2].name = "ovf_pos";    vecs[2].smp = '{25600, 25600, 25600, 25600};
    vecs[2].exp_out = 131071;    vecs[2].exp_sat = 1'b1;
    vecs[3].name = "ovf_neg";    vecs[3].smp = '{-32768, -32768, -32768, -32768};
    vecs[3].exp_out = -131072;   vecs[3].exp_sat = 1'b1;
`else
    vecs[2].name = "ovf_pos";    vecs[2].smp = '{25600, 25600, 25600, 25600};
    vecs[2].exp_out = -114688;   vecs[2].exp_sat = 1'b0;
    vecs[3].name = "ovf_neg";    vecs[3].smp = '{-32768, -32768, -32768, -32768};
    vecs[3].exp_out = 0;         vecs[3].exp_sat = 1'b0;
`endif

    // Reset state
    #1;
    chk("rst_out", out_s(), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_count", longint'(count), 0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", longint'(in_ready), 1);

    // Table windows, out_ready held high
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      for (int k = 0; k < NS; k++) begin
        accept(vecs[i].smp[k]);
        chk({vecs[i].name, "_count"}, longint'(count), longint'((k + 1) % NS));
        if (k < NS - 1) chk({vecs[i].name, "_early_valid"}, longint'(out_valid), 0);
      end
      chk({vecs[i].name, "_valid"}, longint'(out_valid), 1);
      chk({vecs[i].name, "_out"}, out_s(), vecs[i].exp_out);
      chk({vecs[i].name, "_hold_ready"}, longint'(in_ready), 0);
      check_sat({vecs[i].name, "_sat"}, vecs[i].exp_sat);
      @(posedge clk); #1;
      chk({vecs[i].name, "_valid_drop"}, longint'(out_valid), 0);
      chk({vecs[i].name, "_out_kept"}, out_s(), vecs[i].exp_out);
      chk({vecs[i].name, "_ready_back"}, longint'(in_ready), 1);
    end

    // Backpressure: sum held 5 cycles, upstream waits for handshake + 1
    out_ready = 1'b0;
    for (int k = 0; k < NS; k++) accept(384);
    in_d = IW'(256);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_out", out_s(), 6144);
      chk("bp_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid", longint'(out_valid), 0);
    chk("bp_hs_count", longint'(count), 0);
    chk("bp_hs_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    chk("bp_first_accept", longint'(count), 1);
    in_valid = 1'b0;
    for (int k = 0; k < NS - 1; k++) accept(256);
    chk("bp_second_out", out_s(), 4096);
    @(posedge clk); #1;

    // Clear discards the partial window and blocks the same-cycle sample
    accept(768);
    accept(768);
    chk("clr_pre_count", longint'(count), 2);
    clear = 1'b1;
    in_d = IW'(1792);
    in_valid = 1'b1;
    #1;
    chk("clr_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", longint'(count), 0);
    for (int k = 0; k < NS; k++) accept(256);
    chk("clr_out", out_s(), 4096);
    chk("clr_valid", longint'(out_valid), 1);
    @(posedge clk); #1;

    // Clear during HOLD is ignored
    out_ready = 1'b0;
    for (int k = 0; k < NS; k++) accept(384);
    clear = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    clear = 1'b0;
    chk("clr_hold_valid", longint'(out_valid), 1);
    chk("clr_hold_out", out_s(), 6144);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("clr_hold_delivered", longint'(out_valid), 0);

    // Asynchronous reset mid-HOLD
    out_ready = 1'b0;
    for (int k = 0; k < NS; k++) accept(128);
    chk("ar_pre_out", out_s(), 2048);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", longint'(out_valid), 0);
    chk("ar_out", out_s(), 0);
    chk("ar_count", longint'(count), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < NS; k++) accept(384);
    chk("ar_fresh_out", out_s(), 6144);
    @(posedge clk); #1;

    // Randomized windows against the integer model
    out_ready = 1'b0;
    for (int w = 0; w < 20; w++) begin
      model_sum = 0;
      for (int k = 0; k < NS; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
        v = int'($signed(IW'($urandom)));
        model_sum += longint'(v) * SCALE;
        accept(v);
      end
      exp_o = narrow_ref(model_sum);
      chk("rnd_valid", longint'(out_valid), 1);
      chk("rnd_out", out_s(), exp_o);
`ifdef SVREAL_ACCUM_SAT_EN
      chk("rnd_sat", longint'(sat_flag), longint'(clip_ref(model_sum)));
`endif
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      chk("rnd_out_stable", out_s(), exp_o);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rnd_valid_drop", longint'(out_valid), 0);
      out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
